// File: rtl/word_packer_pkg.sv
// Shared definitions for the byte-to-word packer: data widths and the
// packer state encoding.
package word_packer_pkg;

   localparam int BYTE_W = 8;
   localparam int WORD_W = 16;

   // EMPTY: nothing held, HIGH: high byte held, FULL: complete word held
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      HIGH  = 2'd1,
      FULL  = 2'd2
   } packState_t;

endpackage

// File: rtl/word_packer_shl8.sv
// Shift-left-by-8 stage of the datapath, byte-input form: places a byte in
// the upper half of a word and zero-fills the lower half.
module word_packer_shl8
   import word_packer_pkg::*;
(
   input  logic [BYTE_W-1:0] a,
   output logic [WORD_W-1:0] y
);

   // Each result bit is either a zero fill or the source bit eight places down
   for (genvar gi = 0; gi < WORD_W; gi++) begin : gShift
      if (gi < 8) begin : gFill
         assign y[gi] = 1'b0;
      end else begin : gMove
         assign y[gi] = a[gi-8];
      end
   end

endmodule

// File: rtl/word_packer.sv
// Byte-to-word packer: first byte of each pair goes to [15:8], second to
// [7:0]. Valid/ready on both sides, registered word output, handoff counter.
// Optional feature: define WORD_PACKER_FLUSH_EN to add a flush input that
// emits a lone high byte as {byte, 8'h00}.
module word_packer
   import word_packer_pkg::*;
#(
   parameter int CNT_W = 16
)(
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        inData,
   input  logic              inValid,
   output logic              inReady,
   output logic [15:0]       outData,
   output logic              outValid,
   input  logic              outReady,
   output logic              hiPending,
   output logic [CNT_W-1:0]  wordCount
`ifdef WORD_PACKER_FLUSH_EN
   ,
   input  logic              flush
`endif
);

   packState_t         stateReg;
   packState_t         stateNext;
   logic [15:0]        outDataReg;
   logic [CNT_W-1:0]   wordCountReg;
   logic [15:0]        shiftedByte;
   logic               flushReq;
   logic               accept;
   logic               handoff;

`ifdef WORD_PACKER_FLUSH_EN
   assign flushReq = flush;
`else
   assign flushReq = 1'b0;
`endif

   assign accept  = inValid && inReady;
   assign handoff = outValid && outReady;

   word_packer_shl8 uShl8 (
      .a (inData),
      .y (shiftedByte)
   );

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         stateReg <= EMPTY;
      end else begin
         stateReg <= stateNext;
      end
   end

   // Next-state decision from handshakes and flush
   always_comb begin
      stateNext = stateReg;
      case (stateReg)
         EMPTY: begin
            if (accept) stateNext = HIGH;
         end
         HIGH: begin
            if (flushReq)    stateNext = FULL;
            else if (accept) stateNext = FULL;
         end
         FULL: begin
            // accept only happens together with a handoff, so no bubble
            if (handoff) stateNext = accept ? HIGH : EMPTY;
         end
         default: stateNext = EMPTY;
      endcase
   end

   // Handshake and status outputs decoded from the state register
   always_comb begin
      inReady   = 1'b0;
      outValid  = 1'b0;
      hiPending = 1'b0;
      case (stateReg)
         EMPTY: inReady = 1'b1;
         HIGH: begin
            inReady   = !flushReq;
            hiPending = 1'b1;
         end
         FULL: begin
            inReady  = outReady;
            outValid = 1'b1;
         end
         default: inReady = 1'b0;
      endcase
   end

   // Word register: high-byte load via the shift stage, low-byte fill, flush pad
   always_ff @(posedge clk) begin
      if (reset) begin
         outDataReg <= 16'h0000;
      end else begin
         case (stateReg)
            EMPTY: begin
               if (accept) outDataReg <= shiftedByte;
            end
            HIGH: begin
               if (flushReq)    outDataReg[7:0] <= 8'h00;
               else if (accept) outDataReg[7:0] <= inData;
            end
            FULL: begin
               if (accept) outDataReg <= shiftedByte;
            end
            default: outDataReg <= outDataReg;
         endcase
      end
   end

   // Count completed handoffs, wrapping naturally at the counter width
   always_ff @(posedge clk) begin
      if (reset) begin
         wordCountReg <= '0;
      end else if (handoff) begin
         wordCountReg <= wordCountReg + 1'b1;
      end
   end

   assign outData   = outDataReg;
   assign wordCount = wordCountReg;

endmodule

// File: tb/tb_word_packer.sv
// Scoreboard bench for word_packer: a byte-pair model predicts words and
// handshake levels; a monitor compares each presented word and the handoff
// counters of a 16-bit and a 2-bit counter instance.
`timescale 1ns/1ps
module tb_word_packer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  inData = 8'h00;
   logic        inValid = 1'b0;
   logic        outReady = 1'b0;
`ifdef WORD_PACKER_FLUSH_EN
   logic        flushV = 1'b0;
`endif

   logic        inReady, outValid, hiPending;
   logic [15:0] outData;
   logic [15:0] wordCount;
   logic        sInReady, sOutValid, sHiPending;
   logic [15:0] sOutData;
   logic [1:0]  sWordCount;

   int errors = 0;
   int checks = 0;

   logic [15:0] expQ[$];
   bit          hiHeld = 0;
   logic [7:0]  hiByte = 8'h00;
   bit          wordWaiting = 0;
   int          handoffs = 0;

   always #5 clk = ~clk;

   word_packer #(.CNT_W(16)) dut (
      .clk(clk), .reset(reset), .inData(inData), .inValid(inValid),
      .inReady(inReady), .outData(outData), .outValid(outValid),
      .outReady(outReady), .hiPending(hiPending), .wordCount(wordCount)
`ifdef WORD_PACKER_FLUSH_EN
      , .flush(flushV)
`endif
   );

   word_packer #(.CNT_W(2)) dutSmall (
      .clk(clk), .reset(reset), .inData(inData), .inValid(inValid),
      .inReady(sInReady), .outData(sOutData), .outValid(sOutValid),
      .outReady(outReady), .hiPending(sHiPending), .wordCount(sWordCount)
`ifdef WORD_PACKER_FLUSH_EN
      , .flush(flushV)
`endif
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc(input logic v, input logic [7:0] d, input logic r);
      inValid  = v;
      inData   = d;
      outReady = r;
      @(posedge clk);
      #1;
   endtask

   // Reference model: tracks held byte / waiting word and forms words from pairs
   always @(negedge clk) begin
      bit flushEff, expInReady, handoff, accept;
      if (reset) begin
         hiHeld      = 0;
         wordWaiting = 0;
         expQ.delete();
      end else begin
`ifdef WORD_PACKER_FLUSH_EN
         flushEff = flushV;
`else
         flushEff = 1'b0;
`endif
         expInReady = wordWaiting ? outReady : !(hiHeld && flushEff);
         chk("inReady", 32'(inReady), 32'(expInReady));
         chk("outValid", 32'(outValid), 32'(wordWaiting));
         chk("hiPending", 32'(hiPending), 32'(hiHeld));
         chk("small_inReady", 32'(sInReady), 32'(expInReady));
         handoff = wordWaiting && outReady;
         accept  = inValid && expInReady;
         if (handoff) wordWaiting = 0;
         if (hiHeld && flushEff) begin
            expQ.push_back({hiByte, 8'h00});
            hiHeld      = 0;
            wordWaiting = 1;
         end else if (accept) begin
            if (hiHeld) begin
               expQ.push_back({hiByte, inData});
               hiHeld      = 0;
               wordWaiting = 1;
            end else begin
               hiByte = inData;
               hiHeld = 1;
            end
         end
      end
   end

   // Monitor: compare presented words against the queue, count handoffs
   always @(negedge clk) begin
      if (reset) begin
         handoffs = 0;
      end else if (outValid) begin
         if (expQ.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL outData: word %h presented, none expected at %0t", outData, $time);
         end else begin
            chk("outData", 32'(outData), 32'(expQ[0]));
            chk("small_outData", 32'(sOutData), 32'(expQ[0]));
            if (outReady) begin
               chk("wordCount", 32'(wordCount), 32'(handoffs % 65536));
               chk("small_wordCount", 32'(sWordCount), 32'(handoffs % 4));
               $display("handoff word=%h count=%0d small=%0d", outData, wordCount, sWordCount);
               void'(expQ.pop_front());
               handoffs++;
            end
         end
      end
   end

   initial begin
      // Reset state
      reset = 1'b1;
      cyc(0, 8'h00, 1);
      cyc(0, 8'h00, 1);
      reset = 1'b0;
      chk("rst_outData", 32'(outData), 32'h0000);
      chk("rst_outValid", 32'(outValid), 32'h0);
      chk("rst_hiPending", 32'(hiPending), 32'h0);
      chk("rst_wordCount", 32'(wordCount), 32'h0);
      chk("rst_inReady", 32'(inReady), 32'h1);

      // First pair AB, CD
      cyc(1, 8'hAB, 1);
      cyc(1, 8'hCD, 1);
      chk("pair_outData", 32'(outData), 32'hABCD);
      chk("pair_outValid", 32'(outValid), 32'h1);
      cyc(0, 8'h00, 1);
      chk("pair_outValid_drop", 32'(outValid), 32'h0);
      chk("pair_wordCount", 32'(wordCount), 32'h1);

      // Continuous stream 01..06
      for (int i = 1; i <= 6; i++) cyc(1, 8'(i), 1);
      chk("stream_last", 32'(outData), 32'h0506);
      cyc(0, 8'h00, 1);

      // Backpressure hold on 1234, 56 refused then accepted with the handoff
      cyc(1, 8'h12, 0);
      cyc(1, 8'h34, 0);
      for (int i = 0; i < 5; i++) begin
         cyc(1, 8'h56, 0);
         chk("hold_outData", 32'(outData), 32'h1234);
         chk("hold_inReady", 32'(inReady), 32'h0);
      end
      cyc(1, 8'h56, 1);
      chk("release_hiPending", 32'(hiPending), 32'h1);
      chk("release_outValid", 32'(outValid), 32'h0);

      // Reset discards a held byte
      reset = 1'b1;
      cyc(0, 8'h00, 0);
      reset = 1'b0;
      cyc(1, 8'h77, 0);
      chk("r77_hiPending", 32'(hiPending), 32'h1);
      reset = 1'b1;
      cyc(1, 8'h88, 1);
      reset = 1'b0;
      chk("r77_outData", 32'(outData), 32'h0000);
      chk("r77_hiPending_clr", 32'(hiPending), 32'h0);
      chk("r77_wordCount", 32'(wordCount), 32'h0);
      chk("r77_inReady", 32'(inReady), 32'h1);

      // Five words: 2-bit counter wraps 1,2,3,0,1
      for (int i = 0; i < 10; i++) cyc(1, 8'($urandom), 1);
      cyc(0, 8'h00, 1);
      chk("five_wordCount", 32'(wordCount), 32'd5);
      chk("five_small_wordCount", 32'(sWordCount), 32'd1);

`ifdef WORD_PACKER_FLUSH_EN
      // Flush a lone high byte, then flush with nothing held
      cyc(1, 8'h9A, 1);
      flushV = 1'b1;
      cyc(1, 8'h11, 1);
      flushV = 1'b0;
      chk("flush_outData", 32'(outData), 32'h9A00);
      chk("flush_outValid", 32'(outValid), 32'h1);
      cyc(0, 8'h00, 1);
      flushV = 1'b1;
      cyc(0, 8'h00, 1);
      flushV = 1'b0;
      chk("flush_empty_outValid", 32'(outValid), 32'h0);
      chk("flush_empty_hiPending", 32'(hiPending), 32'h0);
`endif

      // Randomized traffic with occasional resets
      for (int i = 0; i < 1500; i++) begin
         reset = ($urandom_range(0, 149) == 0);
`ifdef WORD_PACKER_FLUSH_EN
         flushV = ($urandom_range(0, 5) == 0);
`endif
         cyc(($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 2) != 0));
      end
      reset = 1'b0;
`ifdef WORD_PACKER_FLUSH_EN
      flushV = 1'b0;
`endif
      cyc(0, 8'h00, 1);
      cyc(0, 8'h00, 1);
      cyc(0, 8'h00, 1);
      chk("final_outValid", 32'(outValid), 32'(wordWaiting));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/word_packer.md
# word_packer

Byte-to-word packer that assembles a stream of 8-bit bytes into 16-bit words for the datapath's 16-bit immediate/data bus. First byte of each pair lands in bits [15:8], the same high-byte placement the datapath's shift-left-by-8 stage produces; second byte fills bits [7:0]. Sits between any byte-wide source (serial loader, instruction-memory byte port) and 16-bit consumers, with valid/ready handshakes on both sides and a registered output.

## Interface
- CNT_W, 16, width of the completed-word counter.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high; sampled on rising edge of clk.
- inData  input  8  incoming byte.
- inValid  input  1  inData is valid this cycle.
- inReady  output  1  packer accepts a byte this cycle.
- outData  output  16  assembled word, {high byte, low byte}.
- outValid  output  1  outData holds a complete word.
- outReady  input  1  consumer takes outData this cycle.
- hiPending  output  1  high byte held, low byte awaited.
- wordCount  output  CNT_W  number of words handed off since reset.
- flush  input  1  only with WORD_PACKER_FLUSH_EN; see Configuration.

## Operation
- Byte accepted when inValid && inReady; word handed off when outValid && outReady.
- States: EMPTY (nothing held), HIGH (high byte held in outData[15:8]), FULL (complete word held).
- EMPTY: inReady=1; accepted byte -> outData = {inData, 8'h00}, go HIGH.
- HIGH: inReady=1; accepted byte -> outData[7:0] = inData, go FULL.
- FULL: outValid=1; inReady = outReady. On handoff without accept -> EMPTY. On handoff with simultaneous accept -> outData = {inData, 8'h00}, go HIGH (no bubble). No accept possible without handoff.
- outValid=1 only in FULL; hiPending=1 only in HIGH.
- wordCount increments by 1 on each handoff; wraps from 2^CNT_W-1 to 0.
- outData is stable while outValid && !outReady.
- inData ignored when inValid=0; inReady never depends on inValid.

## Timing
- Reset values: state EMPTY, outData 16'h0000, outValid 0, hiPending 0, wordCount 0, inReady 1 in the cycle after reset deasserts.
- Reset mid-operation discards any held high byte or unconsumed word; no handoff counted.
- Latency: word valid on the clock edge that accepts its low byte; outValid visible the following cycle.
- Sustained throughput: one byte per cycle, one word every two cycles, with outReady held high.
- outValid, outData, hiPending, wordCount are registered; inReady is combinational from state and outReady only.

## Configuration
- WORD_PACKER_FLUSH_EN defined: flush port present. flush=1 in HIGH -> next state FULL with outData = {held byte, 8'h00}, any byte offered that cycle not accepted (inReady=0 in HIGH while flush=1). flush in EMPTY or FULL has no effect. reset has priority over flush.
- Not defined: no flush port; a lone high byte waits in HIGH indefinitely.

## Structure
- Shared package: state encoding constants (EMPTY=2'd0, HIGH=2'd1, FULL=2'd2) and BYTE_W=8, WORD_W=16.
- One sub-module: the datapath's existing shift-left-by-8 block, instantiated to form {inData, 8'h00} for high-byte loads; state register and counter remain in word_packer.

## Test plan
- Reset then bytes 8'hAB, 8'hCD with outReady=1 -> outData=16'hABCD, outValid one cycle, wordCount=1.
- Continuous bytes 8'h01..8'h06, outReady=1 -> words 16'h0102, 16'h0304, 16'h0506 back-to-back, inReady never low.
- Word 16'h1234 held with outReady=0 for 5 cycles -> outData stable, inReady=0, byte 8'h56 not accepted; outReady=1 with 8'h56 offered -> handoff and hiPending=1 next cycle.
- Byte 8'h77 accepted then reset asserted -> state EMPTY, outData=16'h0000, hiPending=0, wordCount unchanged at 0.
- CNT_W=2, five words handed off -> wordCount sequence 1,2,3,0,1.
- With WORD_PACKER_FLUSH_EN: byte 8'h9A then flush=1 -> outData=16'h9A00, outValid=1; flush in EMPTY -> no output.
